param_pipelined_shifter: RTL and testbench
==========================================

Name: param_pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter with selectable shift mode; successor to the combinational left/right shifters.
- Data width is 2^N; one pipeline stage per shift-amount bit, so timing closes at larger widths.
- valid/ready handshakes on input and output, so it sits between streaming datapath blocks and accepts one operand per cycle.

Parameters:
- N, 3, log2 of data width; data width W = 2^N; N >= 1; shift amount is N bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an operand this cycle
- in_ready  output  1  block can accept an operand this cycle
- num  input  W  operand to shift
- shift  input  N  shift amount, 0..W-1
- mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left
- out_valid  output  1  result is valid
- out_ready  input  1  downstream accepts result this cycle
- result  output  W  shifted operand

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits clear; all stage data, shift and mode registers clear to 0; out_valid=0; result=0; in_ready=1 once reset releases.
- Pipeline: N register stages, numbered 0..N-1.
  - Stage k applies a shift of 2^k when its carried shift[k]=1, using the carried mode.
  - Each stage registers data, remaining shift bits, mode and valid.
- Mode rules:
  - LSL: zero-fill from LSB.
  - LSR: zero-fill from MSB.
  - ASR: fill with the original operand MSB; the sign is carried down the pipe.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - shift=0 passes num unchanged in every mode.
- Advance: advance = out_ready || !out_valid; in_ready = advance, combinational from out_ready and the out_valid register.
  - When advance=1, every stage loads from its predecessor; stage 0 loads from inputs, with valid = in_valid.
  - When advance=0, all stages hold.
- Transfer: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: an operand accepted at rising edge t appears on result with out_valid=1 after edge t+N-1, i.e. N cycles, provided no stall.
- Throughput: one operand per cycle when out_ready is held high.
- Bubbles: in_valid=0 on an advancing cycle inserts a bubble. Bubble data is don't-care, but its valid bit must be 0.
- Stall: with out_valid=1 and out_ready=0, result, out_valid and all stage contents stay constant. No operand is dropped or duplicated, and in_ready=0.
- Simultaneous output and input transfer in one cycle is legal; the pipe shifts by one.
- Operand independence: mode and shift are captured per operand, so consecutive operands may use different modes and amounts.
- Reset mid-operation: all in-flight operands are discarded immediately, out_valid drops asynchronously, and no stale result is emitted after release.
- num, shift and mode are sampled only on an input transfer. Their values when in_valid=0 have no effect.

Test Plan:
- N=3, num=8'b1101_0010, shift=3, one operand per mode, out_ready=1 -> results 8'b1001_0000 (LSL), 8'b0001_1010 (LSR), 8'b1111_1010 (ASR), 8'b1001_0110 (ROL). Each appears exactly 3 cycles after acceptance, in order, on consecutive cycles.
- num=8'b1101_0010, shift=0 in all four modes -> result=8'b1101_0010 each time. ASR with num=8'b0101_0010, shift=7 -> 8'b0000_0000; ASR with num=8'b1000_0000, shift=7 -> 8'b1111_1111.
- Stream shift=1..7 with mode=LSR back-to-back -> outputs 8'b0110_1001, 8'b0011_0100, 8'b0001_1010, 8'b0000_1101, 8'b0000_0110, 8'b0000_0011, 8'b0000_0001, one per cycle with no gaps.
- Stream 5 operands, drop out_ready for 4 cycles once the first result is valid:
  - During the stall, result holds its value and in_ready=0.
  - After release, all 5 results emerge in order with no loss or duplication.
- Alternate in_valid 1/0 -> out_valid shows the same 1/0 pattern delayed by 3 cycles, and bubble slots never assert out_valid.
- Assert reset_n low for 1 cycle while 3 operands are in flight -> out_valid=0 and result=0 immediately. After release, out_valid stays 0 until a new operand is accepted and 3 cycles elapse.

Source files
------------

// File: rtl/param_pipelined_shifter.sv
// Pipelined barrel shifter: 2^N-bit operand, one register stage per shift-amount bit.
// Stage k conditionally shifts by 2^k, so the critical path is a single 2:1 shift mux
// level per stage. Valid/ready handshakes on both ends; the whole pipe advances or
// holds as one unit, driven by the output side.
module param_pipelined_shifter #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   num,
  input  logic [N-1:0]      shift,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   result
);

  localparam int W = 2**N;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One fixed-distance shift step. For ASR the fill comes from the current MSB:
  // every earlier ASR step preserved the MSB, so it still equals the original sign.
  function automatic logic [W-1:0] shift_stage(input logic [W-1:0] d,
                                               input logic [1:0]   m,
                                               input int           amt);
    logic [W-1:0] ones;
    logic [W-1:0] sign_fill;
    ones      = '1;
    sign_fill = {W{d[W-1]}} & ~(ones >> amt);
    case (m)
      MODE_LSL: shift_stage = d << amt;
      MODE_LSR: shift_stage = d >> amt;
      MODE_ASR: shift_stage = (d >> amt) | sign_fill;
      MODE_ROL: shift_stage = (d << amt) | (d >> (W - amt));
      default:  shift_stage = d;
    endcase
  endfunction

  // Per-stage registers and the values feeding each stage.
  logic [W-1:0] data_reg  [N];
  logic [N-1:0] shift_reg [N];
  logic [1:0]   mode_reg  [N];
  logic         valid_reg [N];

  logic [W-1:0] data_in   [N];
  logic [N-1:0] shift_in  [N];
  logic [1:0]   mode_in   [N];
  logic         valid_in  [N];

  logic advance;

  // The pipe moves whenever the output slot is empty or being drained this cycle.
  assign out_valid = valid_reg[N-1];
  assign result    = data_reg[N-1];
  assign advance   = out_ready || !out_valid;
  assign in_ready  = advance;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      // Shift-amount bit gi is consumed here; later stages see it cleared.
      localparam logic [N-1:0] KEEP_MASK = ~(N'(1) << gi);

      if (gi == 0) begin : g_head
        assign data_in[gi]  = num;
        assign shift_in[gi] = shift;
        assign mode_in[gi]  = mode;
        assign valid_in[gi] = in_valid;
      end else begin : g_link
        assign data_in[gi]  = data_reg[gi-1];
        assign shift_in[gi] = shift_reg[gi-1];
        assign mode_in[gi]  = mode_reg[gi-1];
        assign valid_in[gi] = valid_reg[gi-1];
      end

      // Stage register: apply a 2^gi shift if requested, then hand everything on.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg[gi]  <= '0;
          shift_reg[gi] <= '0;
          mode_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (advance) begin
          data_reg[gi]  <= shift_in[gi][gi] ? shift_stage(data_in[gi], mode_in[gi], 1 << gi)
                                            : data_in[gi];
          shift_reg[gi] <= shift_in[gi] & KEEP_MASK;
          mode_reg[gi]  <= mode_in[gi];
          valid_reg[gi] <= valid_in[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_pipelined_shifter.sv
// Self-checking bench for param_pipelined_shifter at N=3 (8-bit data).
module tb_param_pipelined_shifter;

  localparam int N = 3;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] num;
  logic [2:0] shift;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  param_pipelined_shifter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .shift     (shift),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic on the operand, no per-stage decomposition.
  function automatic logic [7:0] ref_shift(input logic [7:0] v, input logic [2:0] s,
                                           input logic [1:0] m);
    logic [15:0] wide;
    int          x;
    case (m)
      2'd0: begin wide = {8'h00, v} << s; return wide[7:0]; end
      2'd1: return v >> s;
      2'd2: begin x = int'($signed(v)); x = x >>> s; return x[7:0]; end
      default: begin wide = {v, v} << s; return wide[15:8]; end
    endcase
  endfunction

  task automatic drive(input bit v, input logic [7:0] n, input logic [2:0] s,
                       input logic [1:0] m);
    in_valid = v;
    num      = n;
    shift    = s;
    mode     = m;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // One clock: note transfers just before the edge, keep the expected-result queue.
  task automatic tick(output bit ix, output bit ox, output logic [7:0] got,
                      output logic [7:0] want, output bit have);
    #1;
    ix   = in_valid && in_ready;
    ox   = out_valid && out_ready;
    got  = result;
    want = '0;
    have = 1'b0;
    if (ox && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      have = 1'b1;
    end
    if (ix) exp_q.push_back(ref_shift(num, shift, mode));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    drive(0, 8'h00, 3'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b want=0", out_valid); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got=%h want=00", result); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid: got=%b want=0", out_valid); end
  endtask

  task automatic test_modes();
    logic [1:0] ms[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] ex[4] = '{8'h90, 8'h1A, 8'hFA, 8'h96};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1, 8'hD2, 3'd3, ms[i]); else drive(0, 8'h00, 3'd0, 2'd0);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== (i >= 2 && i <= 5)) begin
        bad++; $display("FAIL modes_valid[%0d]: got=%b want=%b", i, out_valid, (i >= 2 && i <= 5));
      end
      if (i >= 2 && i <= 5) begin
        total++;
        if (result !== ex[i-2]) begin bad++; $display("FAIL modes_result[%0d]: got=%h want=%h", i-2, result, ex[i-2]); end
      end
    end
    idle(3);
  endtask

  task automatic test_zero_and_asr();
    logic [7:0] ns[6] = '{8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h52, 8'h80};
    logic [2:0] ss[6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
    logic [1:0] ms[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [7:0] ex[6] = '{8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h00, 8'hFF};
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1, ns[i], ss[i], ms[i]); else drive(0, 8'h00, 3'd0, 2'd0);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== (i >= 2 && i <= 7)) begin
        bad++; $display("FAIL zero_asr_valid[%0d]: got=%b want=%b", i, out_valid, (i >= 2 && i <= 7));
      end
      if (i >= 2 && i <= 7) begin
        total++;
        if (result !== ex[i-2]) begin bad++; $display("FAIL zero_asr_result[%0d]: got=%h want=%h", i-2, result, ex[i-2]); end
      end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ex[7] = '{8'h69, 8'h34, 8'h1A, 8'h0D, 8'h06, 8'h03, 8'h01};
    for (int i = 0; i < 10; i++) begin
      if (i < 7) drive(1, 8'hD2, 3'(i + 1), 2'd1); else drive(0, 8'h00, 3'd0, 2'd0);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== (i >= 2 && i <= 8)) begin
        bad++; $display("FAIL lsr_stream_valid[%0d]: got=%b want=%b", i, out_valid, (i >= 2 && i <= 8));
      end
      if (i >= 2 && i <= 8) begin
        total++;
        if (result !== ex[i-2]) begin bad++; $display("FAIL lsr_stream_result[%0d]: got=%h want=%h", i-2, result, ex[i-2]); end
      end
    end
    idle(3);
  endtask

  task automatic test_bubbles();
    bit         pat[8];
    logic [7:0] expv[8];
    logic [7:0] n;
    logic [2:0] s;
    logic [1:0] m;
    bit         want_v;
    for (int i = 0; i < 11; i++) begin
      n = 8'($urandom); s = 3'($urandom); m = 2'($urandom);
      if (i < 8) begin
        pat[i]  = (i % 2) == 0;
        expv[i] = ref_shift(n, s, m);
        drive(pat[i], n, s, m);
      end else begin
        drive(0, n, s, m);
      end
      @(posedge clk);
      #1;
      want_v = (i >= 2 && i <= 9) ? pat[i-2] : 1'b0;
      total++;
      if (out_valid !== want_v) begin bad++; $display("FAIL bubble_valid[%0d]: got=%b want=%b", i, out_valid, want_v); end
      if (want_v) begin
        total++;
        if (result !== expv[i-2]) begin bad++; $display("FAIL bubble_result[%0d]: got=%h want=%h", i-2, result, expv[i-2]); end
      end
    end
    idle(3);
  endtask

  task automatic test_stall();
    int         sent = 0;
    int         got_n = 0;
    int         stall_left = -1;
    logic [7:0] held = '0;
    bit         ix, ox, have;
    logic [7:0] got, want;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 40 && got_n < 5; c++) begin
      if (sent < 5 && !in_valid) drive(1, 8'($urandom), 3'($urandom), 2'($urandom));
      if (stall_left < 0 && out_valid) begin stall_left = 4; held = result; end
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      tick(ix, ox, got, want, have);
      if (ix) begin sent++; in_valid = 1'b0; end
      if (ox) begin
        got_n++;
        total++;
        if (!have || got !== want) begin bad++; $display("FAIL stall_order: got=%h want=%h queued=%0d", got, want, have); end
      end
      if (stall_left > 0) begin
        stall_left--;
        total++;
        if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          bad++; $display("FAIL stall_hold: result=%h want=%h out_valid=%b in_ready=%b want 1/0", result, held, out_valid, in_ready);
        end
      end
    end
    out_ready = 1'b1;
    total++; if (got_n != 5) begin bad++; $display("FAIL stall_count: got=%0d want=5", got_n); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_leftover: got=%0d want=0", exp_q.size()); end
    idle(3);
  endtask

  task automatic test_random();
    bit         ix, ox, have;
    logic [7:0] got, want;
    for (int c = 0; c < 300; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      drive($urandom_range(0, 2) != 0, 8'($urandom), 3'($urandom), 2'($urandom));
      tick(ix, ox, got, want, have);
      if (ox) begin
        total++;
        if (!have || got !== want) begin bad++; $display("FAIL random_result[%0d]: got=%h want=%h queued=%0d", c, got, want, have); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(ix, ox, got, want, have);
      if (ox) begin
        total++;
        if (!have || got !== want) begin bad++; $display("FAIL random_drain: got=%h want=%h queued=%0d", got, want, have); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_leftover: got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom) | 8'h01, 3'd0, 2'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got=%b want=0", out_valid); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL midreset_result: got=%h want=00", result); end
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_stale[%0d]: got=%b want=0", i, out_valid); end
    end
    drive(1, 8'hB5, 3'd5, 2'd3);
    want = ref_shift(8'hB5, 3'd5, 2'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      total++;
      if (out_valid !== (i == 2)) begin bad++; $display("FAIL midreset_new_valid[%0d]: got=%b want=%b", i, out_valid, (i == 2)); end
      if (i == 2) begin
        total++;
        if (result !== want) begin bad++; $display("FAIL midreset_new_result: got=%h want=%h", result, want); end
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    drive(0, 8'h00, 3'd0, 2'd0);
    #1;
    test_reset();
    test_modes();
    test_zero_and_asr();
    test_back_to_back();
    test_bubbles();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
